// File: rtl/bch_31_enc_arbiter_if.sv
// Bundles the requester-side and codeword-side handshakes of the shared BCH(31,21) encoder.
// Latency: none, wires only.
// Backpressure: carried by req_ready (to producers) and cw_ready (from the framer).
interface bch_31_enc_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*21-1:0] req_msg;
    logic [N_REQ-1:0]    req_ready;
    logic                cw_valid;
    logic [30:0]         cw_data;
    logic [ID_W-1:0]     cw_src;
    logic                cw_ready;

    // Producer/framer side of the block.
    modport master (
        output req_valid, req_msg, cw_ready,
        input  req_ready, cw_valid, cw_data, cw_src
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_msg, cw_ready,
        output req_ready, cw_valid, cw_data, cw_src
    );
endinterface

// File: rtl/bch_31_enc_arbiter.sv
// Systematic BCH(31,21) encoder, g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1.
// Latency: purely combinational.
// Backpressure: none, stateless.
module bch_31_encoder (
    input  logic [20:0] msg,
    output logic [30:0] cw
);
    // g(x) without its x^10 term; the feedback tap pattern of the divider.
    localparam logic [9:0] GEN_LOW = 10'b1101101001;

    logic [9:0] rem;
    logic       fb;

    // Unrolled serial division of msg * x^10 by g(x), MSB first.
    always_comb begin
        rem = '0;
        fb  = 1'b0;
        for (int i = 20; i >= 0; i--) begin
            fb  = msg[i] ^ rem[9];
            rem = {rem[8:0], 1'b0} ^ (fb ? GEN_LOW : 10'b0);
        end
    end

    assign cw = {msg, rem};
endmodule

// Round-robin share of one BCH(31,21) encoder among N_REQ requesters, source-tagged output.
// Latency: 1 cycle from the accept edge to cw_valid; 1 codeword/cycle when cw_ready stays high.
// Backpressure: output register holds while cw_valid & ~cw_ready; no grants are issued then.
module bch_31_enc_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bch_31_enc_arbiter_if.slave    bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic              load;
    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   rr_ptr;
    logic [20:0]       win_msg;
    logic [30:0]       enc_cw;
    logic [N_REQ-1:0]  ready;
    logic              cw_valid;
    logic [30:0]       cw_data;
    logic [ID_W-1:0]   cw_src;

    // The output slot is free when empty or being drained this cycle.
    assign load = ~cw_valid | bus.cw_ready;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest below it.
    // Loops run high-to-low so the last hit is the lowest index; the second pass overrides the first.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i < int'(rr_ptr))) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(rr_ptr))) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    // Route the winning message into the shared encoder.
    always_comb begin
        win_msg = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                win_msg = bus.req_msg[21*i +: 21];
            end
        end
    end

    // One-hot grant to the winner, suppressed under reset, backpressure or no request.
    always_comb begin
        ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ready[i] = ~rst & load & found & (win == ID_W'(i));
        end
    end

    bch_31_encoder u_enc (
        .msg (win_msg),
        .cw  (enc_cw)
    );

    // Output register and round-robin pointer; pointer moves past the winner on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_valid <= 1'b0;
            cw_data  <= '0;
            cw_src   <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (found) begin
                cw_valid <= 1'b1;
                cw_data  <= enc_cw;
                cw_src   <= win;
                rr_ptr   <= (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
            end else begin
                cw_valid <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.cw_valid  = cw_valid;
    assign bus.cw_data   = cw_data;
    assign bus.cw_src    = cw_src;
endmodule

// File: tb/tb_bch_31_enc_arbiter.sv
module tb_bch_31_enc_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bch_31_enc_arbiter_if #(.N_REQ(4)) bus ();
    bch_31_enc_arbiter_if #(.N_REQ(3)) bus3 ();

    bch_31_enc_arbiter #(.N_REQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    bch_31_enc_arbiter #(.N_REQ(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: long division of msg*x^10 by g(x) on a 31-bit word.
    function automatic logic [30:0] ref_enc(input logic [20:0] msg);
        logic [30:0] v;
        logic [30:0] g;
        g = 31'h769;
        v = {msg, 10'b0};
        for (int b = 30; b >= 10; b--) begin
            if (v[b]) v = v ^ (g << (b - 10));
        end
        return {msg, v[9:0]};
    endfunction

    function automatic int winner(input logic [3:0] v, input int ptr);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (ptr + k) % 4;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [83:0] pk(input logic [20:0] m0, input logic [20:0] m1,
                                       input logic [20:0] m2, input logic [20:0] m3);
        return {m3, m2, m1, m0};
    endfunction

    // Behavioural model of the 4-requester instance.
    logic        m_valid;
    logic [30:0] m_data;
    int          m_src;
    int          m_ptr;
    int          mw;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
        end else begin
            mw = winner(bus.req_valid, m_ptr);
            if (!m_valid || bus.cw_ready) begin
                if (mw >= 0) begin
                    m_valid = 1'b1;
                    m_data  = ref_enc(21'(bus.req_msg >> (21 * mw)));
                    m_src   = mw;
                    m_ptr   = (mw + 1) % 4;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic check_model(input string tag);
        int w;
        logic [3:0] er;
        w  = winner(bus.req_valid, m_ptr);
        er = '0;
        if (!rst && (!m_valid || bus.cw_ready) && w >= 0) er = 4'(1 << w);
        chk({tag, " ready"}, 64'(bus.req_ready), 64'(er));
        chk({tag, " valid"}, 64'(bus.cw_valid), 64'(m_valid));
        chk({tag, " data"},  64'(bus.cw_data),  64'(m_data));
        chk({tag, " src"},   64'(bus.cw_src),   64'(m_src));
    endtask

    typedef struct {
        logic [3:0]  vld;
        logic [83:0] msg;
        logic        crdy;
        logic [3:0]  e_rdy;
        logic        e_cv;
        logic [30:0] e_cd;
        logic [1:0]  e_cs;
    } vec_t;

    vec_t tbl[8];
    logic [20:0] fm[4];
    int seq[6];
    logic [30:0] held;

    initial begin
        logic [20:0] J;
        J = 21'h0ABCDE;
        tbl[0] = '{4'b0001, pk(21'h1, J, J, J),        1'b1, 4'b0001, 1'b1, 31'h00000769, 2'd0};
        tbl[1] = '{4'b0001, pk(21'h0, J, J, J),        1'b1, 4'b0001, 1'b1, 31'h00000000, 2'd0};
        tbl[2] = '{4'b0100, pk(J, J, 21'h1FFFFF, J),   1'b1, 4'b0100, 1'b1, 31'h7FFFFFFF, 2'd2};
        tbl[3] = '{4'b0010, pk(J, 21'h1, J, J),        1'b1, 4'b0010, 1'b1, 31'h00000769, 2'd1};
        tbl[4] = '{4'b0000, pk(J, J, J, J),            1'b1, 4'b0000, 1'b0, 31'h00000769, 2'd1};
        tbl[5] = '{4'b1011, pk(J, J, J, 21'h1FFFFF),   1'b0, 4'b1000, 1'b1, 31'h7FFFFFFF, 2'd3};
        tbl[6] = '{4'b1011, pk(21'h1, J, J, J),        1'b0, 4'b0000, 1'b1, 31'h7FFFFFFF, 2'd3};
        tbl[7] = '{4'b1011, pk(21'h1, J, J, J),        1'b1, 4'b0001, 1'b1, 31'h00000769, 2'd0};
        fm = '{21'h012345, 21'h0F0F0F, 21'h1AAAAA, 21'h155555};
        seq = '{0, 1, 2, 3, 0, 1};

        bus.req_valid = 4'b1111; bus.req_msg = '0; bus.cw_ready = 1'b1;
        bus3.req_valid = '0; bus3.req_msg = '0; bus3.cw_ready = 1'b1;

        // Reset state, with every requester asking.
        #2;
        chk("reset ready", 64'(bus.req_ready), 64'(0));
        chk("reset valid", 64'(bus.cw_valid), 64'(0));
        chk("reset data",  64'(bus.cw_data), 64'(0));
        chk("reset src",   64'(bus.cw_src), 64'(0));
        @(negedge clk); rst = 1'b0; bus.req_valid = '0;

        // Directed table.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_valid = tbl[k].vld; bus.req_msg = tbl[k].msg; bus.cw_ready = tbl[k].crdy;
            #1 chk($sformatf("tbl%0d ready", k), 64'(bus.req_ready), 64'(tbl[k].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d valid", k), 64'(bus.cw_valid), 64'(tbl[k].e_cv));
            chk($sformatf("tbl%0d data", k),  64'(bus.cw_data),  64'(tbl[k].e_cd));
            chk($sformatf("tbl%0d src", k),   64'(bus.cw_src),   64'(tbl[k].e_cs));
        end

        // Fairness from a fresh reset.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus.req_valid = 4'b1111; bus.cw_ready = 1'b1; bus.req_msg = pk(fm[0], fm[1], fm[2], fm[3]);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("fair%0d valid", k), 64'(bus.cw_valid), 64'(1));
            chk($sformatf("fair%0d src", k),   64'(bus.cw_src),   64'(seq[k]));
            chk($sformatf("fair%0d data", k),  64'(bus.cw_data),  64'(ref_enc(fm[seq[k]])));
        end

        // Backpressure: output frozen, no grants; release grants in the same cycle.
        held = bus.cw_data;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.cw_ready = 1'b0;
            #1 chk($sformatf("bp%0d ready", k), 64'(bus.req_ready), 64'(0));
            @(posedge clk); #1;
            chk($sformatf("bp%0d data", k), 64'(bus.cw_data), 64'(held));
            chk($sformatf("bp%0d src", k),  64'(bus.cw_src),  64'(1));
            chk($sformatf("bp%0d valid", k), 64'(bus.cw_valid), 64'(1));
        end
        @(negedge clk); bus.cw_ready = 1'b1;
        #1 chk("bp release ready", 64'(bus.req_ready), 64'(4'b0100));
        @(posedge clk); #1;
        chk("bp release src", 64'(bus.cw_src), 64'(2));

        // Reset mid-stream clears the output without waiting for an edge.
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mid rst valid", 64'(bus.cw_valid), 64'(0));
        chk("mid rst data",  64'(bus.cw_data),  64'(0));
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post rst src",   64'(bus.cw_src),   64'(0));
        chk("post rst valid", 64'(bus.cw_valid), 64'(1));

        // Three requesters: a grant to the last index wraps the pointer to 0.
        @(negedge clk); bus.req_valid = '0; bus3.req_valid = 3'b100;
        @(posedge clk); #1;
        chk("n3 src2", 64'(bus3.cw_src), 64'(2));
        @(negedge clk); bus3.req_valid = 3'b111;
        #1 chk("n3 ready wrap", 64'(bus3.req_ready), 64'(3'b001));
        @(posedge clk); #1;
        chk("n3 src0", 64'(bus3.cw_src), 64'(0));
        @(negedge clk); bus3.req_valid = '0;

        // Random traffic against the model, with occasional resets.
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            bus.req_valid = 4'($urandom);
            bus.req_msg = 84'({$urandom, $urandom, $urandom});
            bus.cw_ready = ($urandom_range(0, 3) != 0);
            #1 check_model($sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
